// File: rtl/spi_master_xip_seq_if.sv
// Request/response streams between a word-read client and the XIP read sequencer.
// The master modport is the requesting client; the slave modport is the sequencer.
interface spi_master_xip_seq_if #(
  parameter int ADDR_BITS = 24,
  parameter int LEN_W     = 7
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_W-1:0]     req_words;
  logic                 abort_i;
  logic [31:0]          rsp_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_last;
  logic                 rsp_err;

  modport master (
    output req_valid, req_addr, req_words, abort_i, rsp_ready,
    input  req_ready, rsp_data, rsp_valid, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_words, abort_i, rsp_ready,
    output req_ready, rsp_data, rsp_valid, rsp_last, rsp_err
  );
endinterface

// File: rtl/spi_master_xip_seq.sv
// XIP read sequencer: turns a word-read request into one SPI controller read transaction
// and streams the RX FIFO out as valid/ready response beats, with timeout/abort error beats.
module spi_master_xip_seq #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_BITS = 24,
  parameter int TIMEOUT   = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cfg_quad_en,
  input  logic [7:0]  cfg_cmd,
  input  logic [15:0] cfg_dummy,
  input  logic [1:0]  cfg_cs_sel,
  spi_master_xip_seq_if.slave bus,
  output logic [31:0] spi_cmd,
  output logic [5:0]  spi_cmd_len,
  output logic [31:0] spi_addr,
  output logic [5:0]  spi_addr_len,
  output logic [15:0] spi_data_len,
  output logic [15:0] spi_dummy_rd,
  output logic [3:0]  spi_csreg,
  output logic        spi_rd,
  output logic        spi_qrd,
  output logic        spi_swrst,
  input  logic        spi_eot,
  input  logic [31:0] spi_rx_data,
  input  logic        spi_rx_valid,
  output logic        spi_rx_ready,
  output logic        seq_busy
);
  localparam int LEN_W = $clog2(MAX_WORDS) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_WAIT_EOT, S_ERR, S_ERR_RSP
  } state_t;

  state_t               state_reg,    state_next;
  logic [ADDR_BITS-1:0] addr_reg,     addr_next;
  logic [LEN_W-1:0]     words_reg,    words_next;
  logic                 quad_reg,     quad_next;
  logic [7:0]           cmd_reg,      cmd_next;
  logic [15:0]          dummy_reg,    dummy_next;
  logic [1:0]           cs_reg,       cs_next;
  logic [LEN_W-1:0]     word_cnt_reg, word_cnt_next;
  logic [TMO_W-1:0]     tmo_reg,      tmo_next;
  logic                 eot_seen_reg, eot_seen_next;

  logic [LEN_W-1:0] last_idx;
  logic             last_beat;
  logic             eot_now;
  logic             tmo_hit;
  logic             req_bad;
  logic             bus_active;

  assign last_idx  = words_reg - LEN_W'(1);
  assign last_beat = (word_cnt_reg == last_idx);
  assign eot_now   = eot_seen_reg | spi_eot;
  assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT - 1));
  assign req_bad   = (bus.req_words == '0) || (bus.req_words > LEN_W'(MAX_WORDS));
  assign seq_busy  = (state_reg != S_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      words_reg    <= '0;
      quad_reg     <= 1'b0;
      cmd_reg      <= '0;
      dummy_reg    <= '0;
      cs_reg       <= '0;
      word_cnt_reg <= '0;
      tmo_reg      <= '0;
      eot_seen_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      words_reg    <= words_next;
      quad_reg     <= quad_next;
      cmd_reg      <= cmd_next;
      dummy_reg    <= dummy_next;
      cs_reg       <= cs_next;
      word_cnt_reg <= word_cnt_next;
      tmo_reg      <= tmo_next;
      eot_seen_reg <= eot_seen_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    words_next    = words_reg;
    quad_next     = quad_reg;
    cmd_next      = cmd_reg;
    dummy_next    = dummy_reg;
    cs_next       = cs_reg;
    word_cnt_next = word_cnt_reg;
    tmo_next      = tmo_reg;
    eot_seen_next = eot_seen_reg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_last  = 1'b0;
    bus.rsp_err   = 1'b0;
    spi_rd        = 1'b0;
    spi_qrd       = 1'b0;
    spi_swrst     = 1'b0;
    spi_rx_ready  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        eot_seen_next = 1'b0;
        if (bus.req_valid) begin
          addr_next     = bus.req_addr;
          words_next    = bus.req_words;
          quad_next     = cfg_quad_en;
          cmd_next      = cfg_cmd;
          dummy_next    = cfg_dummy;
          cs_next       = cfg_cs_sel;
          word_cnt_next = '0;
          // Out-of-range lengths never touch the controller, they just get an error beat.
          state_next    = req_bad ? S_ERR_RSP : S_LOAD;
        end
      end

      S_LOAD: begin
        state_next = bus.abort_i ? S_ERR : S_START;
      end

      S_START: begin
        if (bus.abort_i) begin
          state_next = S_ERR;
        end else begin
          spi_rd        = ~quad_reg;
          spi_qrd       = quad_reg;
          tmo_next      = '0;
          eot_seen_next = spi_eot;
          state_next    = S_DATA;
        end
      end

      S_DATA: begin
        eot_seen_next = eot_now;
        if (bus.abort_i) begin
          state_next = S_ERR;
        end else begin
          bus.rsp_valid = spi_rx_valid;
          bus.rsp_data  = spi_rx_data;
          bus.rsp_last  = last_beat;
          spi_rx_ready  = bus.rsp_ready;
          // Any word at the FIFO head (popped or back-pressured) proves the link is alive.
          if (spi_rx_valid) begin
            tmo_next = '0;
            if (bus.rsp_ready) begin
              word_cnt_next = word_cnt_reg + LEN_W'(1);
              if (last_beat) begin
                state_next = eot_now ? S_IDLE : S_WAIT_EOT;
              end
            end
          end else if (tmo_hit) begin
            state_next = S_ERR;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
      end

      S_WAIT_EOT: begin
        if (bus.abort_i) begin
          state_next = S_ERR;
        end else if (spi_eot) begin
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          state_next = S_ERR;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      S_ERR: begin
        spi_swrst  = 1'b1;
        state_next = S_ERR_RSP;
      end

      S_ERR_RSP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = 1'b1;
        bus.rsp_err   = 1'b1;
        if (bus.rsp_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Control bus is only presented while this request owns the controller.
  always_comb begin
    bus_active   = state_reg inside {S_LOAD, S_START, S_DATA, S_WAIT_EOT, S_ERR};
    spi_cmd      = '0;
    spi_cmd_len  = '0;
    spi_addr     = '0;
    spi_addr_len = '0;
    spi_data_len = '0;
    spi_dummy_rd = '0;
    spi_csreg    = '0;
    if (bus_active) begin
      spi_cmd      = {cmd_reg, 24'h0};
      spi_cmd_len  = 6'd8;
      spi_addr     = 32'(addr_reg) << (32 - ADDR_BITS);
      spi_addr_len = 6'(ADDR_BITS);
      spi_data_len = 16'(words_reg) << 5;
      spi_dummy_rd = dummy_reg;
      spi_csreg    = 4'b0001 << cs_reg;
    end
  end
endmodule
